// File: rtl/video_tx_timing_pkg.sv
// video_tx_timing_pkg: FSM state encoding, 720p default timing and RGB565 field widths.
package video_tx_timing_pkg;
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;
  localparam int CNT_W = 12;
  localparam int R_W = 5, G_W = 6, B_W = 5;
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int DEF_H_DISP = 1280, DEF_H_FP = 110, DEF_H_SYNC = 40, DEF_H_BP = 220;
  localparam int DEF_V_DISP = 720, DEF_V_FP = 5, DEF_V_SYNC = 5, DEF_V_BP = 20;
endpackage

// File: rtl/video_tx_timing_if.sv
// video_tx_timing_if: upstream pixel handshake plus registered video output bundle.
interface video_tx_timing_if;
  import video_tx_timing_pkg::*;
  logic pix_valid, pix_sof, pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic vo_hs, vo_vs, vo_de, frame_start;
  logic [PIX_W-1:0] vo_data;
  modport master(output pix_valid, pix_sof, pix_data, input pix_ready, vo_hs, vo_vs, vo_de, vo_data, frame_start);
  modport slave(input pix_valid, pix_sof, pix_data, output pix_ready, vo_hs, vo_vs, vo_de, vo_data, frame_start);
endinterface

// File: rtl/video_timing_cnt.sv
// video_timing_cnt: free-running h/v raster counters with active and sync region decode.
module video_timing_cnt
  import video_tx_timing_pkg::*;
#(
  parameter int H_DISP = DEF_H_DISP,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             h_sync,
  output logic             v_sync
);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_DISP + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  always_ff @(posedge clk)
    if (rst || clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + CNT_W'(1);
      v_cnt <= (h_cnt != H_LAST) ? v_cnt : (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign h_sync = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign v_sync = (v_cnt >= V_SS) && (v_cnt < V_SE);
endmodule

// File: rtl/video_tx_timing.sv
// video_tx_timing: raster generator that locks an upstream RGB565 stream to frame origin.
module video_tx_timing
  import video_tx_timing_pkg::*;
#(
  parameter int              H_DISP     = DEF_H_DISP,
  parameter int              H_FP       = DEF_H_FP,
  parameter int              H_SYNC     = DEF_H_SYNC,
  parameter int              H_BP       = DEF_H_BP,
  parameter int              V_DISP     = DEF_V_DISP,
  parameter int              V_FP       = DEF_V_FP,
  parameter int              V_SYNC     = DEF_V_SYNC,
  parameter int              V_BP       = DEF_V_BP,
  parameter logic            HS_POL     = 1'b1,
  parameter logic            VS_POL     = 1'b1,
  parameter logic [PIX_W-1:0] FILL_COLOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_status,
  video_tx_timing_if.slave bus,
  output logic             underflow,
  output logic             resync_err
);
  state_t state, state_n;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic active, h_sync, v_sync, origin, sof_hit, lock, live, show, ev_uf, ev_rs;
  video_timing_cnt #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk(clk), .rst(rst), .clr(!en || state == IDLE),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active), .h_sync(h_sync), .v_sync(v_sync)
  );
  always_comb begin
    origin = (h_cnt == '0) && (v_cnt == '0);
    sof_hit = bus.pix_valid && bus.pix_sof;
    live = state != IDLE;
    lock = state == ALIGN && origin && sof_hit;
    bus.pix_ready = (state == ALIGN) ? bus.pix_valid && (!bus.pix_sof || origin)
                                     : state == RUN && active && !(sof_hit && !origin);
    show = bus.pix_ready && bus.pix_valid && (lock || state == RUN);
    ev_uf = state == RUN && active && !bus.pix_valid;
    // a SOF off-origin or a non-SOF at origin both mean the stream lost frame alignment
    ev_rs = state == RUN && bus.pix_valid && (bus.pix_sof != origin);
    state_n = !en ? IDLE : (state == IDLE) ? ALIGN : lock ? RUN
            : (state == RUN && sof_hit && !origin) ? ALIGN : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bus.vo_de <= 1'b0;
      bus.vo_data <= '0;
      bus.vo_hs <= !HS_POL;
      bus.vo_vs <= !VS_POL;
      bus.frame_start <= 1'b0;
      underflow <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      state <= state_n;
      bus.vo_de <= live && active;
      bus.vo_data <= !(live && active) ? '0 : show ? bus.pix_data : FILL_COLOR;
      bus.vo_hs <= (live && h_sync) ? HS_POL : !HS_POL;
      bus.vo_vs <= (live && v_sync) ? VS_POL : !VS_POL;
      bus.frame_start <= origin && (lock || state == RUN);
      underflow <= ev_uf || (underflow && !clr_status);
      resync_err <= ev_rs || (resync_err && !clr_status);
    end
endmodule

// File: tb/tb_video_tx_timing.sv
// tb_video_tx_timing: directed vector table plus hand-written sequences on a reduced raster.
module tb_video_tx_timing;
  localparam logic [15:0] FILL = 16'hF81F;
  localparam int FT = 120;
  typedef struct {
    logic en, pv, sof, clr;
    logic [15:0] d;
    logic rdy, de;
    logic [15:0] dat;
    logic hs, vs, fs, uf, rs;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr_status = 1'b0;
  logic underflow, resync_err;
  int tests = 0, fails = 0, cons = 0, derr = 0;
  int fs_n, fs_last, fs_bad, de_cnt, de_bad, hs_n, hs_last, hs_bad, hs_hi, vs_n, vs_last, vs_bad, vs_lo, n, rdy_n, badf;
  logic prev_hs, prev_vs;
  vec_t vec[19];
  video_tx_timing_if bus();
  video_tx_timing #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .FILL_COLOR(FILL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr_status(clr_status),
    .bus(bus.slave), .underflow(underflow), .resync_err(resync_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic e, input logic pv, input logic sof, input logic [15:0] d, input logic c);
    en = e;
    bus.pix_valid = pv;
    bus.pix_sof = sof;
    bus.pix_data = d;
    clr_status = c;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic src(input logic c);
    logic took;
    logic [15:0] d;
    d = 16'(cons);
    drive(1'b1, 1'b1, cons == 0, d, c);
    #1 took = bus.pix_ready;
    tick();
    if (took) cons++;
    if (bus.vo_de && (!took || bus.vo_data !== d)) derr++;
  endtask
  function automatic vec_t mk(logic e, logic pv, logic sof, logic c, logic [15:0] d, logic rdy, logic de,
                              logic [15:0] dat, logic hs, logic vs, logic fs, logic uf, logic rs);
    vec_t v;
    v.en = e; v.pv = pv; v.sof = sof; v.clr = c; v.d = d;
    v.rdy = rdy; v.de = de; v.dat = dat; v.hs = hs; v.vs = vs; v.fs = fs; v.uf = uf; v.rs = rs;
    return v;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec[0]  = mk(1,1,1,0,16'h1111, 0,0,16'h0000, 0,1,0,0,0);
    vec[1]  = mk(1,1,1,0,16'h1111, 1,1,16'h1111, 0,1,1,0,0);
    vec[2]  = mk(1,1,0,0,16'h2222, 1,1,16'h2222, 0,1,0,0,0);
    vec[3]  = mk(1,0,0,0,16'h0000, 1,1,FILL,     0,1,0,1,0);
    vec[4]  = mk(1,1,0,1,16'h4444, 1,1,16'h4444, 0,1,0,0,0);
    vec[5]  = mk(1,0,0,1,16'h0000, 1,1,FILL,     0,1,0,1,0);
    vec[6]  = mk(1,1,0,0,16'h6666, 1,1,16'h6666, 0,1,0,1,0);
    vec[7]  = mk(1,1,0,1,16'h7777, 1,1,16'h7777, 0,1,0,0,0);
    vec[8]  = mk(1,1,0,0,16'h8888, 1,1,16'h8888, 0,1,0,0,0);
    vec[9]  = mk(1,1,0,0,16'h9999, 0,0,16'h0000, 0,1,0,0,0);
    vec[10] = mk(1,1,0,0,16'h9999, 0,0,16'h0000, 0,1,0,0,0);
    vec[11] = mk(1,1,0,0,16'h9999, 0,0,16'h0000, 1,1,0,0,0);
    vec[12] = mk(1,1,0,0,16'h9999, 0,0,16'h0000, 1,1,0,0,0);
    vec[13] = mk(1,1,0,0,16'h9999, 0,0,16'h0000, 1,1,0,0,0);
    vec[14] = mk(1,1,0,0,16'h9999, 0,0,16'h0000, 0,1,0,0,0);
    vec[15] = mk(1,1,0,0,16'h9999, 0,0,16'h0000, 0,1,0,0,0);
    vec[16] = mk(1,1,0,0,16'hAAAA, 1,1,16'hAAAA, 0,1,0,0,0);
    vec[17] = mk(1,1,1,0,16'hBBBB, 0,1,FILL,     0,1,0,0,1);
    vec[18] = mk(1,1,0,0,16'hCCCC, 1,1,FILL,     0,1,0,0,1);
    drive(0, 0, 0, 16'h0, 0);
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_de", bus.vo_de, 0);
    chk("rst_data", bus.vo_data, 0);
    chk("rst_hs", bus.vo_hs, 0);
    chk("rst_vs", bus.vo_vs, 1);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_ready", bus.pix_ready, 0);
    chk("rst_flags", {underflow, resync_err}, 0);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      drive(vec[i].en, vec[i].pv, vec[i].sof, vec[i].d, vec[i].clr);
      #1 chk($sformatf("v%0d_ready", i), bus.pix_ready, vec[i].rdy);
      tick();
      chk($sformatf("v%0d_de", i), bus.vo_de, vec[i].de);
      chk($sformatf("v%0d_data", i), bus.vo_data, vec[i].dat);
      chk($sformatf("v%0d_hs", i), bus.vo_hs, vec[i].hs);
      chk($sformatf("v%0d_vs", i), bus.vo_vs, vec[i].vs);
      chk($sformatf("v%0d_fs", i), bus.frame_start, vec[i].fs);
      chk($sformatf("v%0d_uf", i), underflow, vec[i].uf);
      chk($sformatf("v%0d_rs", i), resync_err, vec[i].rs);
    end
    // continuous stream: SOF only on the very first pixel
    rst = 1'b1;
    drive(0, 0, 0, 16'h0, 0);
    repeat (2) tick();
    rst = 1'b0;
    fs_n = 0; fs_last = -1; fs_bad = 0; de_cnt = 0; de_bad = 0;
    hs_n = 0; hs_last = -1; hs_bad = 0; hs_hi = 0;
    vs_n = 0; vs_last = -1; vs_bad = 0; vs_lo = 0;
    prev_hs = 1'b0; prev_vs = 1'b1;
    for (int c = 0; c < 4 * FT; c++) begin
      src(1'b0);
      if (bus.frame_start) begin
        if (fs_last >= 0 && (c - fs_last != FT || de_cnt != 32)) fs_bad++;
        fs_last = c; fs_n++; de_cnt = 0;
      end
      if (bus.vo_de) de_cnt++;
      if (bus.vo_hs && !prev_hs) begin
        if (hs_last >= 0 && c - hs_last != 15) hs_bad++;
        hs_last = c; hs_n++;
      end
      if (!bus.vo_vs && prev_vs) begin
        if (vs_last >= 0 && c - vs_last != FT) vs_bad++;
        vs_last = c; vs_n++;
      end
      hs_hi += int'(bus.vo_hs);
      vs_lo += int'(!bus.vo_vs);
      prev_hs = bus.vo_hs; prev_vs = bus.vo_vs;
    end
    chk("stream_frames", fs_n, 4);
    chk("stream_frame_period_de", fs_bad, 0);
    chk("stream_hs_rises", hs_n, 32);
    chk("stream_hs_period", hs_bad, 0);
    chk("stream_hs_width", hs_hi, 96);
    chk("stream_vs_falls", vs_n, 4);
    chk("stream_vs_period", vs_bad, 0);
    chk("stream_vs_width", vs_lo, 120);
    chk("stream_data", derr, 0);
    chk("stream_pixels", cons, 4 * 32);
    chk("stream_underflow", underflow, 0);
    chk("stream_origin_nonsof_resync", resync_err, 1);
    // SOF injected at h=3, v=2 while running
    n = 0;
    do begin src(1'b0); n++; end while (!bus.frame_start && n < 2 * FT);
    chk("resync_find_origin", bus.frame_start, 1);
    src(1'b1);
    repeat (31) src(1'b0);
    chk("resync_cleared", resync_err, 0);
    drive(1, 1, 1, 16'hCAFE, 0);
    #1 chk("resync_ready", bus.pix_ready, 0);
    tick();
    chk("resync_flag", resync_err, 1);
    chk("resync_de", bus.vo_de, 1);
    chk("resync_fill", bus.vo_data, FILL);
    n = 0; rdy_n = 0; badf = 0;
    do begin
      drive(1, 1, 1, 16'hCAFE, 0);
      #1 rdy_n += int'(bus.pix_ready);
      tick();
      n++;
      if (!bus.frame_start && bus.vo_de && bus.vo_data !== FILL) badf++;
    end while (!bus.frame_start && n < 2 * FT);
    chk("resync_lock_delay", n, 87);
    chk("resync_sof_held", rdy_n, 1);
    chk("resync_fill_until_origin", badf, 0);
    chk("resync_lock_data", bus.vo_data, 16'hCAFE);
    // non-SOF pixel at origin while running
    drive(1, 1, 0, 16'h0001, 1);
    tick();
    chk("clr_resync", resync_err, 0);
    repeat (118) begin drive(1, 1, 0, 16'h0002, 0); tick(); end
    drive(1, 1, 0, 16'hD00D, 0);
    #1 chk("origin_nonsof_ready", bus.pix_ready, 1);
    tick();
    chk("origin_nonsof_rs", resync_err, 1);
    chk("origin_nonsof_fs", bus.frame_start, 1);
    chk("origin_nonsof_data", bus.vo_data, 16'hD00D);
    drive(1, 1, 0, 16'hE00E, 0);
    tick();
    chk("origin_nonsof_stays_run", bus.vo_data, 16'hE00E);
    // enable dropped in horizontal sync
    repeat (8) begin drive(1, 1, 0, 16'h0003, 0); tick(); end
    drive(0, 1, 0, 16'h0004, 0);
    tick();
    chk("en_off_hs_still", bus.vo_hs, 1);
    #1 chk("en_off_ready", bus.pix_ready, 0);
    tick();
    chk("en_off_de", bus.vo_de, 0);
    chk("en_off_hs", bus.vo_hs, 0);
    chk("en_off_vs", bus.vo_vs, 1);
    chk("en_off_data", bus.vo_data, 0);
    tick();
    chk("en_off_idle_de", bus.vo_de, 0);
    drive(1, 1, 1, 16'hF00D, 0);
    #1 chk("reen_idle_ready", bus.pix_ready, 0);
    tick();
    #1 chk("reen_align_origin_ready", bus.pix_ready, 1);
    tick();
    chk("reen_fs", bus.frame_start, 1);
    chk("reen_data", bus.vo_data, 16'hF00D);
    // reset mid-frame
    drive(1, 1, 0, 16'h1234, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_de", bus.vo_de, 0);
    chk("midrst_data", bus.vo_data, 0);
    chk("midrst_syncs", {bus.vo_hs, bus.vo_vs}, 2'b01);
    chk("midrst_fs", bus.frame_start, 0);
    chk("midrst_flags", {underflow, resync_err}, 0);
    chk("midrst_ready", bus.pix_ready, 0);
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
